prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Boot-time program writer for the single-cycle processor.
- Accepts a stream of 32-bit instruction words and writes them into instruction memory at consecutive word addresses from the text base.
- Holds the processor's start_up input asserted for the whole load, plus a settle interval, then releases it so the CPU fetches from the base PC.
- Sits between the testbench or host link and the processor/imem pair.

Parameters:
ADDR_BASE, 32'h0040_0000, byte address of the first instruction word.
DEPTH_LOG2, 10, log2 of imem capacity in words; maximum load length is 2**DEPTH_LOG2.
HOLD_CYCLES, 2, cycles cpu_start_up stays high after the last write; legal range 1..15.

Ports:
clk  in  1  system clock, rising edge.
start_up  in  1  synchronous active-high reset.
load_req  in  1  one-cycle request to begin a load; honoured only in IDLE or RUN.
load_len  in  DEPTH_LOG2+1  word count, sampled with load_req.
s_valid  in  1  stream word valid.
s_data  in  32  stream instruction word.
s_ready  out  1  loader accepts a word this cycle.
imem_we  out  1  instruction memory write enable.
imem_addr  out  32  byte address of the write.
imem_wdata  out  32  write data.
cpu_start_up  out  1  drives the processor's start_up input.
busy  out  1  high in LOAD or HOLD.
done  out  1  one-cycle pulse on entry to RUN.
err  out  1  sticky bad-request flag.
word_count  out  DEPTH_LOG2+1  words accepted in the current load.

Behaviour:
- Reset values (start_up=1 at a clock edge): state=IDLE, s_ready=0, imem_we=0, imem_addr=ADDR_BASE, imem_wdata=0, cpu_start_up=1, busy=0, done=0, err=0, word_count=0.
- States are IDLE, LOAD, HOLD and RUN.
- IDLE:
  - cpu_start_up=1.
  - load_req with 1 <= load_len <= 2**DEPTH_LOG2: latch len, word_count=0, clear err, go to LOAD.
  - load_req with any other length: set err and stay in IDLE.
- LOAD:
  - s_ready=1 while word_count < len.
  - A handshake is s_valid & s_ready.
  - On each handshake, the next cycle drives imem_we=1, imem_addr=ADDR_BASE+4*word_count (old value) and imem_wdata=s_data. This is a registered write with 1-cycle latency.
  - word_count increments on each handshake.
  - The handshake that makes word_count==len also sets s_ready=0 for the next cycle and moves to HOLD.
  - A gap in s_valid stalls the load indefinitely; no timeout.
- HOLD:
  - The final imem write occurs in the first HOLD cycle.
  - cpu_start_up stays 1 for exactly HOLD_CYCLES cycles, then the block goes to RUN.
- RUN:
  - cpu_start_up=0, busy=0.
  - done=1 for the first RUN cycle only.
  - A valid load_req re-enters LOAD with cpu_start_up=1 asserted the next cycle. Memory is rewritten from ADDR_BASE.
  - An invalid load_req sets err and stays in RUN with the CPU running.
- load_req in LOAD or HOLD is ignored; err is unchanged.
- s_valid outside LOAD is ignored; s_ready=0 and no write occurs.
- Address arithmetic is modulo 2**32; no wrap check beyond the length limit.
- start_up asserted mid-load: next cycle all state returns to reset values and any pending imem write is dropped. The partially written memory is not cleared.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - Adds input exp_sum[31:0], sampled with load_req.
  - Adds output chk_sum[31:0], the modulo-2**32 sum of accepted words, cleared on load start.
  - After the last handshake, if chk_sum+last word != exp_sum, the block goes to IDLE with err=1 instead of HOLD, and cpu_start_up stays 1.
  - If the sums match, behaviour is as normal.
- Undefined: the ports are absent and no check is performed.

Test Plan:
- Reset, then load_req with load_len=3 and words 0x20080005, 0x20090007, 0x01095020, with s_valid held high -> imem writes to 0x00400000/04/08 on consecutive cycles; cpu_start_up falls 2 cycles after the last write; done pulses once; word_count=3.
- Same load with s_valid toggling 1,0,0,1,0,1 -> same three writes, each one cycle after its handshake; no write on idle cycles; s_ready stays 1 until the 3rd word.
- load_len=0, then load_len=1025 (DEPTH_LOG2=10) -> err=1, state stays IDLE, no writes; a following load_len=1 clears err.
- start_up pulsed after the 2nd of 4 words -> the next cycle shows imem_we=0, word_count=0, cpu_start_up=1, state IDLE; the 3rd s_valid word is not accepted.
- In RUN, load_req with load_len=2 -> cpu_start_up rises the next cycle; writes restart at 0x00400000; done pulses again on re-entry to RUN.
- With PROG_LOADER_CHECKSUM_EN and words 1, 2, 3: exp_sum=6 -> RUN; exp_sum=7 -> IDLE with err=1 and cpu_start_up held at 1.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: streams boot instruction words into imem and holds the CPU in start-up until loaded.
// Optional load checksum verification is enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter logic [31:0] ADDR_BASE   = 32'h0040_0000,
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic                clk,
    input  logic                start_up,
    input  logic                load_req,
    input  logic [DEPTH_LOG2:0] load_len,
    input  logic                s_valid,
    input  logic [31:0]         s_data,
    output logic                s_ready,
    output logic                imem_we,
    output logic [31:0]         imem_addr,
    output logic [31:0]         imem_wdata,
    output logic                cpu_start_up,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [DEPTH_LOG2:0] word_count
`ifdef PROG_LOADER_CHECKSUM_EN
    ,
    input  logic [31:0]         exp_sum,
    output logic [31:0]         chk_sum
`endif
);

    localparam int unsigned CW      = DEPTH_LOG2 + 1;
    localparam logic [31:0] MAX_LEN = 32'(1) << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_RUN
    } state_t;

    state_t          r_state;
    state_t          r_next;
    logic [CW-1:0]   r_len;
    logic [CW-1:0]   r_word_count;
    logic            r_err;
    logic            r_we;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [3:0]      r_hold_cnt;
    logic            r_done;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [31:0]     r_sum;
    logic [31:0]     r_exp;
    logic [31:0]     w_sum_nxt;
`endif

    logic            w_req_ok;
    logic            w_can_start;
    logic            w_start;
    logic            w_bad_req;
    logic            w_ready;
    logic            w_hs;
    logic [CW-1:0]   w_count_nxt;
    logic            w_last;
    logic            w_sum_bad;
    logic            w_hold_end;

    always_comb begin
        w_req_ok    = (32'(load_len) >= 32'd1) && (32'(load_len) <= MAX_LEN);
        w_can_start = (r_state == S_IDLE) || (r_state == S_RUN);
        w_start     = load_req && w_req_ok && w_can_start;
        w_bad_req   = load_req && !w_req_ok && w_can_start;
        w_ready     = (r_state == S_LOAD) && (r_word_count < r_len);
        w_hs        = w_ready && s_valid;
        w_count_nxt = r_word_count + CW'(1);
        w_last      = w_hs && (w_count_nxt == r_len);
`ifdef PROG_LOADER_CHECKSUM_EN
        w_sum_nxt   = r_sum + s_data;
        w_sum_bad   = w_last && (w_sum_nxt != r_exp);
`else
        w_sum_bad   = 1'b0;
`endif
        w_hold_end  = (r_hold_cnt == 4'(HOLD_CYCLES - 1));

        r_next       = r_state;
        s_ready      = w_ready;
        cpu_start_up = (r_state != S_RUN);
        busy         = (r_state == S_LOAD) || (r_state == S_HOLD);

        case (r_state)
            S_IDLE: if (w_start) r_next = S_LOAD;
            S_LOAD: if (w_last) r_next = w_sum_bad ? S_IDLE : S_HOLD;
            S_HOLD: if (w_hold_end) r_next = S_RUN;
            S_RUN:  if (w_start) r_next = S_LOAD;
            default: r_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (start_up) r_state <= S_IDLE;
        else          r_state <= r_next;
    end

    // The write is registered: a handshake this cycle lands on imem next cycle.
    always_ff @(posedge clk) begin
        if (start_up) begin
            r_len        <= '0;
            r_word_count <= '0;
            r_err        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= ADDR_BASE;
            r_wdata      <= '0;
            r_hold_cnt   <= '0;
            r_done       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_sum        <= '0;
            r_exp        <= '0;
`endif
        end else begin
            r_we   <= w_hs;
            r_done <= (r_state == S_HOLD) && w_hold_end;

            if (r_state == S_HOLD) r_hold_cnt <= r_hold_cnt + 4'd1;
            else                   r_hold_cnt <= '0;

            if (w_hs) begin
                r_addr       <= ADDR_BASE + (32'(r_word_count) << 2);
                r_wdata      <= s_data;
                r_word_count <= w_count_nxt;
`ifdef PROG_LOADER_CHECKSUM_EN
                r_sum        <= w_sum_nxt;
`endif
            end

            if (w_start) begin
                r_len        <= load_len;
                r_word_count <= '0;
                r_err        <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                r_sum        <= '0;
                r_exp        <= exp_sum;
`endif
            end

            if (w_bad_req || w_sum_bad) r_err <= 1'b1;
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign done       = r_done;
    assign err        = r_err;
    assign word_count = r_word_count;
`ifdef PROG_LOADER_CHECKSUM_EN
    assign chk_sum    = r_sum;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed vector table, checksum sequences, then random stimulus vs a reference model.
// Checksum sequences and ports are included when PROG_LOADER_CHECKSUM_EN is defined.
module tb_prog_loader;

    localparam logic [31:0] B  = 32'h0040_0000;
    localparam logic [31:0] W0 = 32'h2008_0005;
    localparam logic [31:0] W1 = 32'h2009_0007;
    localparam logic [31:0] W2 = 32'h0109_5020;
    localparam logic [31:0] A1 = 32'h1111_0001;
    localparam logic [31:0] A2 = 32'h2222_0002;
    localparam logic [31:0] J  = 32'hDEAD_BEEF;
    localparam logic [31:0] SW = W0 + W1 + W2;
    localparam logic [31:0] SA = A1 + A2;
    localparam int HOLD = 2;

    logic        clk = 1'b0;
    logic        start_up;
    logic        load_req;
    logic [10:0] load_len;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_start_up;
    logic        busy;
    logic        done;
    logic        err;
    logic [10:0] word_count;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [31:0] exp_sum;
    logic [31:0] chk_sum;
`endif

    always #5 clk = ~clk;

    prog_loader #(
        .ADDR_BASE  (B),
        .DEPTH_LOG2 (10),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk         (clk),
        .start_up    (start_up),
        .load_req    (load_req),
        .load_len    (load_len),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .cpu_start_up(cpu_start_up),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .word_count  (word_count)
`ifdef PROG_LOADER_CHECKSUM_EN
        ,
        .exp_sum     (exp_sum),
        .chk_sum     (chk_sum)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        su, req;
        logic [10:0] len;
        logic        v;
        logic [31:0] d, es;
        logic        rdy, we;
        logic [31:0] addr, data;
        logic        cpu, bsy, dn, er;
        logic [10:0] wc;
    } vec_t;

    function automatic vec_t mk(input logic su, input logic req, input int len, input logic v,
                                input logic [31:0] d, input logic [31:0] es, input logic rdy,
                                input logic we, input logic [31:0] addr, input logic [31:0] data,
                                input logic cpu, input logic bsy, input logic dn, input logic er,
                                input int wc);
        vec_t r;
        r.su = su; r.req = req; r.len = 11'(len); r.v = v; r.d = d; r.es = es;
        r.rdy = rdy; r.we = we; r.addr = addr; r.data = data;
        r.cpu = cpu; r.bsy = bsy; r.dn = dn; r.er = er; r.wc = 11'(wc);
        return r;
    endfunction

    vec_t tbl[$];

    // Reference model: flags and counters derived from the loader's rules.
    bit          m_loading, m_holding, m_running, m_we, m_done, m_err;
    int          m_len, m_cnt, m_hold_left;
    logic [31:0] m_addr, m_data;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [31:0] m_sum, m_exp;
    bit          zmode;
`endif

    task automatic model_reset();
        m_loading = 0; m_holding = 0; m_running = 0; m_we = 0; m_done = 0; m_err = 0;
        m_len = 0; m_cnt = 0; m_hold_left = 0; m_addr = B; m_data = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
        m_sum = '0; m_exp = '0;
`endif
    endtask

    task automatic model_step();
        bit rdy;
        if (start_up) begin
            model_reset();
            return;
        end
        rdy    = m_loading && (m_cnt < m_len);
        m_we   = rdy && s_valid;
        m_done = 0;
        if (m_we) begin
            m_addr = B + 32'(m_cnt * 4);
            m_data = s_data;
            m_cnt++;
`ifdef PROG_LOADER_CHECKSUM_EN
            m_sum = m_sum + s_data;
`endif
            if (m_cnt == m_len) begin
                m_loading = 0;
                m_holding = 1;
                m_hold_left = HOLD;
`ifdef PROG_LOADER_CHECKSUM_EN
                if (m_sum != m_exp) begin
                    m_holding = 0;
                    m_err = 1;
                end
`endif
            end
        end else if (m_holding) begin
            m_hold_left--;
            if (m_hold_left == 0) begin
                m_holding = 0;
                m_running = 1;
                m_done = 1;
            end
        end else if (!m_loading && load_req) begin
            if (int'(load_len) >= 1 && int'(load_len) <= 1024) begin
                m_loading = 1; m_running = 0;
                m_len = int'(load_len); m_cnt = 0; m_err = 0;
`ifdef PROG_LOADER_CHECKSUM_EN
                m_sum = '0; m_exp = exp_sum;
`endif
            end else begin
                m_err = 1;
            end
        end
    endtask

    task automatic model_compare();
        check1("rnd_s_ready", s_ready, m_loading && (m_cnt < m_len));
        check1("rnd_imem_we", imem_we, m_we);
        if (m_we) begin
            check32("rnd_imem_addr", imem_addr, m_addr);
            check32("rnd_imem_wdata", imem_wdata, m_data);
        end
        check1("rnd_cpu_start_up", cpu_start_up, !m_running);
        check1("rnd_busy", busy, m_loading || m_holding);
        check1("rnd_done", done, m_done);
        check1("rnd_err", err, m_err);
        check32("rnd_word_count", 32'(word_count), 32'(m_cnt));
`ifdef PROG_LOADER_CHECKSUM_EN
        check32("rnd_chk_sum", chk_sum, m_sum);
`endif
    endtask

`ifdef PROG_LOADER_CHECKSUM_EN
    task automatic cs_load(input logic [31:0] es, input logic expect_run);
        @(negedge clk);
        load_req = 1; load_len = 11'd3; exp_sum = es; s_valid = 0;
        @(negedge clk);
        load_req = 0;
        for (int k = 1; k <= 3; k++) begin
            s_valid = 1; s_data = 32'(k);
            @(negedge clk);
        end
        s_valid = 0;
        repeat (4) @(negedge clk);
        check1("cs_cpu_start_up", cpu_start_up, !expect_run);
        check1("cs_err", err, !expect_run);
        check1("cs_busy", busy, 1'b0);
        check32("cs_chk_sum", chk_sum, 32'd6);
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        start_up = 1; load_req = 0; load_len = '0; s_valid = 0; s_data = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
        exp_sum = '0;
`endif
        repeat (3) @(negedge clk);
        check1("rst_s_ready", s_ready, 1'b0);
        check1("rst_imem_we", imem_we, 1'b0);
        check32("rst_imem_addr", imem_addr, B);
        check32("rst_imem_wdata", imem_wdata, 32'd0);
        check1("rst_cpu_start_up", cpu_start_up, 1'b1);
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_err", err, 1'b0);
        check32("rst_word_count", 32'(word_count), 32'd0);

        // su req len v d es | rdy we addr data | cpu busy done err wc
        tbl.push_back(mk(0,1,3,0,0,SW,  0,0,0,0,     1,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,W0,0,  1,0,0,0,     1,1,0,0,0));
        tbl.push_back(mk(0,0,0,1,W1,0,  1,1,B,W0,    1,1,0,0,1));
        tbl.push_back(mk(0,0,0,1,W2,0,  1,1,B+4,W1,  1,1,0,0,2));
        tbl.push_back(mk(0,0,0,1,J,0,   0,1,B+8,W2,  1,1,0,0,3));
        tbl.push_back(mk(0,0,0,0,0,0,   0,0,0,0,     1,1,0,0,3));
        tbl.push_back(mk(0,0,0,0,0,0,   0,0,0,0,     0,0,1,0,3));
        tbl.push_back(mk(0,0,0,0,0,0,   0,0,0,0,     0,0,0,0,3));
        tbl.push_back(mk(0,1,2,0,0,SA,  0,0,0,0,     0,0,0,0,3));
        tbl.push_back(mk(0,0,0,1,A1,0,  1,0,0,0,     1,1,0,0,0));
        tbl.push_back(mk(0,0,0,1,A2,0,  1,1,B,A1,    1,1,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,   0,1,B+4,A2,  1,1,0,0,2));
        tbl.push_back(mk(0,0,0,0,0,0,   0,0,0,0,     1,1,0,0,2));
        tbl.push_back(mk(0,0,0,0,0,0,   0,0,0,0,     0,0,1,0,2));
        tbl.push_back(mk(0,1,3,0,0,SW,  0,0,0,0,     0,0,0,0,2));
        tbl.push_back(mk(0,0,0,1,W0,0,  1,0,0,0,     1,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,   1,1,B,W0,    1,1,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,   1,0,0,0,     1,1,0,0,1));
        tbl.push_back(mk(0,0,0,1,W1,0,  1,0,0,0,     1,1,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,   1,1,B+4,W1,  1,1,0,0,2));
        tbl.push_back(mk(0,0,0,1,W2,0,  1,0,0,0,     1,1,0,0,2));
        tbl.push_back(mk(0,0,0,0,0,0,   0,1,B+8,W2,  1,1,0,0,3));
        tbl.push_back(mk(0,0,0,0,0,0,   0,0,0,0,     1,1,0,0,3));
        tbl.push_back(mk(0,0,0,0,0,0,   0,0,0,0,     0,0,1,0,3));
        tbl.push_back(mk(0,1,0,0,0,0,   0,0,0,0,     0,0,0,0,3));
        tbl.push_back(mk(0,0,0,1,J,0,   0,0,0,0,     0,0,0,1,3));
        tbl.push_back(mk(1,0,0,0,0,0,   0,0,0,0,     0,0,0,1,3));
        tbl.push_back(mk(0,1,0,0,0,0,   0,0,0,0,     1,0,0,0,0));
        tbl.push_back(mk(0,1,1025,0,0,0,0,0,0,0,     1,0,0,1,0));
        tbl.push_back(mk(0,0,0,1,J,0,   0,0,0,0,     1,0,0,1,0));
        tbl.push_back(mk(0,1,1,0,0,W0,  0,0,0,0,     1,0,0,1,0));
        tbl.push_back(mk(0,0,0,1,W0,0,  1,0,0,0,     1,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,   0,1,B,W0,    1,1,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,   0,0,0,0,     1,1,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,   0,0,0,0,     0,0,1,0,1));
        tbl.push_back(mk(0,1,4,0,0,0,   0,0,0,0,     0,0,0,0,1));
        tbl.push_back(mk(0,0,0,1,W0,0,  1,0,0,0,     1,1,0,0,0));
        tbl.push_back(mk(0,0,0,1,W1,0,  1,1,B,W0,    1,1,0,0,1));
        tbl.push_back(mk(1,0,0,1,W2,0,  1,1,B+4,W1,  1,1,0,0,2));
        tbl.push_back(mk(0,0,0,1,J,0,   0,0,0,0,     1,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,   0,0,0,0,     1,0,0,0,0));

        foreach (tbl[i]) begin
            @(negedge clk);
            start_up = tbl[i].su; load_req = tbl[i].req; load_len = tbl[i].len;
            s_valid = tbl[i].v; s_data = tbl[i].d;
`ifdef PROG_LOADER_CHECKSUM_EN
            exp_sum = tbl[i].es;
`endif
            #1;
            check1($sformatf("vec%0d_s_ready", i), s_ready, tbl[i].rdy);
            check1($sformatf("vec%0d_imem_we", i), imem_we, tbl[i].we);
            if (tbl[i].we) begin
                check32($sformatf("vec%0d_imem_addr", i), imem_addr, tbl[i].addr);
                check32($sformatf("vec%0d_imem_wdata", i), imem_wdata, tbl[i].data);
            end
            check1($sformatf("vec%0d_cpu_start_up", i), cpu_start_up, tbl[i].cpu);
            check1($sformatf("vec%0d_busy", i), busy, tbl[i].bsy);
            check1($sformatf("vec%0d_done", i), done, tbl[i].dn);
            check1($sformatf("vec%0d_err", i), err, tbl[i].er);
            check32($sformatf("vec%0d_word_count", i), 32'(word_count), 32'(tbl[i].wc));
        end
        start_up = 0; load_req = 0; s_valid = 0;

`ifdef PROG_LOADER_CHECKSUM_EN
        cs_load(32'd6, 1'b1);
        cs_load(32'd7, 1'b0);
`endif

        for (int c = 0; c < 5000; c++) begin
            int r;
            @(negedge clk);
            if (c > 0) model_compare();
            start_up = (c == 0) || ($urandom_range(0, 199) == 0);
            load_req = ($urandom_range(0, 9) == 0);
            r = int'($urandom_range(0, 19));
            case (r)
                0:       load_len = 11'd0;
                1:       load_len = 11'd1025;
                2:       load_len = 11'd1024;
                3:       load_len = 11'd2047;
                default: load_len = 11'($urandom_range(1, 5));
            endcase
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = $urandom;
`ifdef PROG_LOADER_CHECKSUM_EN
            if (load_req) begin
                zmode = $urandom_range(0, 1) == 1;
                exp_sum = zmode ? 32'd0 : $urandom;
            end
            if (zmode) s_data = '0;
`endif
            model_step();
        end
        @(negedge clk);
        model_compare();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
